// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute sequencer for the ALU; define ALU_MULTICYCLE_EN for multi-cycle MUL/MOD
module alu_exec_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int MOD_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] alu_result,
  input  logic [1:0]  flag,
  input  logic        mem_ready,
  output logic        en_exe_pulse,
  output logic [31:0] alu_result_reg,
  output logic [1:0]  flag_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
  state_t state;
  logic [4:0] op;
  logic last, is_nop, is_lad, is_str, is_sub;
  if (MUL_LAT < 1 || MOD_LAT < 1) begin : g_lat_check
    $error("MUL_LAT and MOD_LAT must be at least 1");
  end
  assign is_lad = op == 5'b10110;
  assign is_str = op == 5'b10111;
  assign is_sub = op inside {5'b00100, 5'b00101};
  assign is_nop = !(op inside {[5'b00010:5'b10111], 5'b11100, 5'b11101});
`ifdef ALU_MULTICYCLE_EN
  logic [31:0] cnt, len_m1;
  assign len_m1 = opcode inside {5'b00110, 5'b00111} ? 32'(MUL_LAT - 1) :
                  opcode inside {5'b01000, 5'b01001} ? 32'(MOD_LAT - 1) : '0;
  assign last = cnt == '0;
  // Remaining EXEC cycles: loaded on accept, counted down to zero in EXEC
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (state == IDLE && start) cnt <= len_m1;
    else if (state == EXEC && !last) cnt <= cnt - 32'd1;
`else
  assign last = 1'b1;
`endif
  // Instruction sequencing plus the architectural result/flag registers
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      op <= '0;
      alu_result_reg <= '0;
      flag_reg <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op <= opcode;
          state <= EXEC;
        end
        EXEC: if (last) begin
          if (!is_nop && !is_str) alu_result_reg <= alu_result;
          if (is_sub) flag_reg <= flag;
          state <= (is_lad || is_str) ? MEM : is_nop ? IDLE : WB;
        end
        MEM: if (mem_ready) state <= is_lad ? WB : IDLE;
        default: state <= IDLE;
      endcase
    end
  assign en_exe_pulse = state == EXEC;
  assign mem_req = state == MEM;
  assign mem_we = state == MEM && is_str;
  assign rf_we = state == WB;
  assign wb_sel = state == WB && is_lad;
  assign busy = state != IDLE;
  assign done = state == WB || (state == EXEC && last && is_nop) || (state == MEM && mem_ready && is_str);
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed table, hand sequences and random instructions against a transaction-level model
module tb_alu_exec_ctrl;
  localparam int MUL_LAT = 4;
  localparam int MOD_LAT = 8;
`ifdef ALU_MULTICYCLE_EN
  localparam int MUL_TOT = MUL_LAT + 1;
  localparam int MOD_TOT = MOD_LAT + 1;
`else
  localparam int MUL_TOT = 2;
  localparam int MOD_TOT = 2;
`endif
  logic clk, reset, start, mem_ready;
  logic [4:0] opcode;
  logic [31:0] alu_result;
  logic [1:0] flag;
  logic en_exe_pulse, mem_req, mem_we, rf_we, wb_sel, busy, done;
  logic [31:0] alu_result_reg;
  logic [1:0] flag_reg;
  int pass_n = 0;
  int total_n = 0;
  logic [31:0] m_res = '0;
  logic [1:0] m_flag = '0;

  alu_exec_ctrl #(.MUL_LAT(MUL_LAT), .MOD_LAT(MOD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .alu_result(alu_result),
    .flag(flag), .mem_ready(mem_ready), .en_exe_pulse(en_exe_pulse), .alu_result_reg(alu_result_reg),
    .flag_reg(flag_reg), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we), .wb_sel(wb_sel),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    int          k;
    logic [31:0] base;
    logic [1:0]  fbase;
    int          lat;
    int          rf;
    logic        wbs;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One instruction from IDLE to done; expectations come from the opcode class rules
  task automatic do_instr(input logic [4:0] op, input int k, input logic [31:0] base,
                          input logic [1:0] fbase, output int lat, output int rf_n, output logic wbs);
    int L, en_n, mreq_n, mwe_n, c, e_lat;
    bit fin, is_lad, is_str, is_mem, is_arith, is_nop;
    logic [31:0] r_last;
    logic [1:0] f_last;
    is_lad = op == 5'b10110;
    is_str = op == 5'b10111;
    is_mem = is_lad || is_str;
    is_arith = op inside {[5'd2:5'd15], [5'd16:5'd21], 5'd28, 5'd29};
    is_nop = !is_arith && !is_mem;
    L = 1;
`ifdef ALU_MULTICYCLE_EN
    if (op inside {5'd6, 5'd7}) L = MUL_LAT;
    else if (op inside {5'd8, 5'd9}) L = MOD_LAT;
`endif
    lat = 0; rf_n = 0; wbs = 1'b0; en_n = 0; mreq_n = 0; mwe_n = 0;
    r_last = '0; f_last = '0;
    start = 1'b1; opcode = op; alu_result = $urandom; flag = 2'($urandom); mem_ready = 1'($urandom);
    #1 chk("idle_busy", {31'd0, busy}, 0);
    step();
    c = 1; fin = 0;
    while (!fin && c <= 40) begin
      start = 1'($urandom);
      opcode = 5'($urandom);
      alu_result = base + 32'(c);
      flag = fbase + 2'(c);
      if (c == L) begin r_last = alu_result; f_last = flag; end
      mem_ready = (is_mem && c > L && c <= L + k) ? (c == L + k) : 1'($urandom);
      #1;
      en_n += int'(en_exe_pulse);
      mreq_n += int'(mem_req);
      mwe_n += int'(mem_we);
      rf_n += int'(rf_we);
      if (rf_we) wbs = wb_sel;
      if (done) begin lat = c; fin = 1; end
      step();
      c++;
    end
    start = 1'b0;
    mem_ready = 1'b0;
    if (!is_nop && !is_str) m_res = r_last;
    if (op inside {5'd4, 5'd5}) m_flag = f_last;
    e_lat = is_nop ? L : is_str ? L + k : is_lad ? L + k + 1 : L + 1;
    chk($sformatf("lat op%0d", op), lat, e_lat);
    chk($sformatf("en op%0d", op), en_n, L);
    chk($sformatf("mem_req op%0d", op), mreq_n, is_mem ? k : 0);
    chk($sformatf("mem_we op%0d", op), mwe_n, is_str ? k : 0);
    chk($sformatf("rf_we op%0d", op), rf_n, (is_nop || is_str) ? 0 : 1);
    chk($sformatf("wb_sel op%0d", op), {31'd0, wbs}, {31'd0, is_lad});
    chk($sformatf("res op%0d", op), alu_result_reg, m_res);
    chk($sformatf("flag op%0d", op), {30'd0, flag_reg}, {30'd0, m_flag});
  endtask

  initial begin
    vec_t tbl[10];
    int lat, rf_n, dn;
    logic wbs;
    tbl[0] = '{5'b00100, 1, 32'd2, 2'd2, 2, 1, 1'b0};
    tbl[1] = '{5'b00010, 1, 32'h100, 2'd0, 2, 1, 1'b0};
    tbl[2] = '{5'b00110, 1, 32'h200, 2'd1, MUL_TOT, 1, 1'b0};
    tbl[3] = '{5'b01000, 1, 32'h300, 2'd1, MOD_TOT, 1, 1'b0};
    tbl[4] = '{5'b10110, 3, 32'h400, 2'd0, 5, 1, 1'b1};
    tbl[5] = '{5'b10111, 1, 32'h500, 2'd0, 2, 0, 1'b0};
    tbl[6] = '{5'b00000, 1, 32'h600, 2'd0, 1, 0, 1'b0};
    tbl[7] = '{5'b11000, 1, 32'h700, 2'd0, 1, 0, 1'b0};
    tbl[8] = '{5'b11100, 1, 32'h800, 2'd0, 2, 1, 1'b0};
    tbl[9] = '{5'b10101, 1, 32'h900, 2'd0, 2, 1, 1'b0};
    reset = 1'b1; start = 1'b0; opcode = '0; alu_result = '0; flag = '0; mem_ready = 1'b0;
    repeat (2) step();
    chk("rst en", {31'd0, en_exe_pulse}, 0);
    chk("rst res", alu_result_reg, 0);
    chk("rst flag", {30'd0, flag_reg}, 0);
    chk("rst outs", {25'd0, mem_req, mem_we, rf_we, wb_sel, busy, done}, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("idle busy", {31'd0, busy}, 0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      do_instr(tbl[i].op, tbl[i].k, tbl[i].base, tbl[i].fbase, lat, rf_n, wbs);
      chk($sformatf("tbl%0d lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d rf", i), rf_n, tbl[i].rf);
      chk($sformatf("tbl%0d wbs", i), {31'd0, wbs}, {31'd0, tbl[i].wbs});
      if (i == 0) chk("sub res", alu_result_reg, 32'd3);
      if (i == 1) chk("add keeps flag", {30'd0, flag_reg}, 32'd3);
    end
    start = 1'b1; opcode = 5'b00010; alu_result = 32'h1234_5678; dn = 0;
    for (int i = 0; i < 9; i++) begin
      #1 dn += int'(done);
      step();
    end
    start = 1'b0;
    m_res = 32'h1234_5678;
    chk("b2b done count", dn, 3);
    chk("b2b res", alu_result_reg, m_res);
    start = 1'b1; opcode = 5'b10111; mem_ready = 1'b0;
    step();
    start = 1'b0;
    #1 chk("abort exec", {31'd0, en_exe_pulse}, 1);
    step();
    #1 chk("abort mem1 we", {31'd0, mem_we}, 1);
    step();
    reset = 1'b1;
    #1 chk("abort mem2", {30'd0, mem_req, done}, 32'b10);
    step();
    reset = 1'b0;
    #1 chk("abort after", {28'd0, mem_req, busy, done, rf_we}, 0);
    m_res = '0; m_flag = '0;
    step();
    for (int i = 0; i < 60; i++)
      do_instr(5'($urandom), $urandom_range(1, 4), $urandom, 2'($urandom), lat, rf_n, wbs);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
